// File: rtl/pattern_det_pkg.sv
// Shared constants and sizing helper for the multi-channel pattern detector.
package pattern_det_pkg;

    localparam logic OVL_ON  = 1'b1;
    localparam logic OVL_OFF = 1'b0;

    // Width of a counter that must represent 0..pat_w inclusive.
    function automatic int fill_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/pattern_det_lane.sv
// One serial lane: bit history, saturating fill count, registered hit pulse and,
// when PATTERN_DET_COUNT_EN is defined, a saturating match counter.
module pattern_det_lane
    import pattern_det_pkg::*;
#(
    parameter int PAT_W = 4
`ifdef PATTERN_DET_COUNT_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             a_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             y_out
`ifdef PATTERN_DET_COUNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    localparam int FW = fill_w(PAT_W);

    // The oldest bit is shifted out before it is ever compared, so only
    // PAT_W-1 bits of history need to be kept between valid bits.
    logic [PAT_W-2:0] hist;
    logic [PAT_W-1:0] hist_n;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    fill_n;
    logic             hit;

    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        hist_n = {hist, a_in};
        fill_n = (fill == FW'(PAT_W)) ? fill : fill + FW'(1);
        hit    = (fill_n == FW'(PAT_W)) && (hist_n == pattern);
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist  <= '0;
            fill  <= '0;
            y_out <= 1'b0;
`ifdef PATTERN_DET_COUNT_EN
            match_cnt <= '0;
`endif
        end else if (in_valid) begin
            hist  <= hist_n[PAT_W-2:0];
            // Non-overlapping mode restarts the fill so the next match needs PAT_W fresh bits.
            fill  <= (hit && overlap == OVL_OFF) ? '0 : fill_n;
            y_out <= hit;
`ifdef PATTERN_DET_COUNT_EN
            if (hit && match_cnt != '1)
                match_cnt <= match_cnt + CNT_W'(1);
`endif
        end else begin
            y_out <= 1'b0;
        end
    end

endmodule

// File: rtl/pattern_detector_mc.sv
// CH independent serial pattern-detector lanes sharing one programmable pattern.
// Optional per-lane match counters are enabled by defining PATTERN_DET_COUNT_EN.
module pattern_detector_mc
    import pattern_det_pkg::*;
#(
    parameter int CH    = 4,
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                in_valid,
    input  logic [CH-1:0]       a_in,
    input  logic [PAT_W-1:0]    pattern,
    input  logic                overlap,
    output logic [CH-1:0]       y_out
`ifdef PATTERN_DET_COUNT_EN
    ,
    output logic [CH*CNT_W-1:0] match_cnt
`endif
);

    if (CH < 1 || PAT_W < 2 || CNT_W < 1) begin : g_param_check
        $error("pattern_detector_mc: need CH >= 1, PAT_W >= 2, CNT_W >= 1");
    end

    for (genvar c = 0; c < CH; c++) begin : g_lane
        pattern_det_lane #(
            .PAT_W(PAT_W)
`ifdef PATTERN_DET_COUNT_EN
            ,
            .CNT_W(CNT_W)
`endif
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr),
            .in_valid (in_valid),
            .a_in     (a_in[c]),
            .pattern  (pattern),
            .overlap  (overlap),
            .y_out    (y_out[c])
`ifdef PATTERN_DET_COUNT_EN
            ,
            .match_cnt(match_cnt[c*CNT_W +: CNT_W])
`endif
        );
    end

endmodule

// File: tb/tb_pattern_detector_mc.sv
// Directed self-checking bench for pattern_detector_mc (CH=4, PAT_W=4, CNT_W=2);
// counter checks are compiled in only when PATTERN_DET_COUNT_EN is defined.
module tb_pattern_detector_mc;

    localparam int CH    = 4;
    localparam int PAT_W = 4;
    localparam int CNT_W = 2;

    // Lane-0 stream for the overlap tests, first bit in the MSB.
    localparam logic [6:0] T1_BITS = 7'b1011011;
    localparam logic [6:0] T1_OVL  = 7'b0001001;
    localparam logic [6:0] T1_NOV  = 7'b0001000;
    localparam logic [3:0] SEQ     = 4'b1011;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                clr = 1'b0;
    logic                in_valid = 1'b0;
    logic [CH-1:0]       a_in = '0;
    logic [PAT_W-1:0]    pattern = 4'b1011;
    logic                overlap = 1'b1;
    logic [CH-1:0]       y_out;
`ifdef PATTERN_DET_COUNT_EN
    logic [CH*CNT_W-1:0] match_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    pattern_detector_mc #(
        .CH   (CH),
        .PAT_W(PAT_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .a_in     (a_in),
        .pattern  (pattern),
        .overlap  (overlap),
        .y_out    (y_out)
`ifdef PATTERN_DET_COUNT_EN
        ,
        .match_cnt(match_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Apply one cycle of inputs, then sample 1 ns after the edge that consumed them.
    task automatic drive(input logic r, input logic c, input logic v, input logic [CH-1:0] bits);
        rst      = r;
        clr      = c;
        in_valid = v;
        a_in     = bits;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        drive(1'b1, 1'b0, 1'b0, '0);
        rst = 1'b0;
    endtask

    task automatic check_cnt(input string tag, input logic [7:0] exp);
`ifdef PATTERN_DET_COUNT_EN
        check(tag, 32'(match_cnt), 32'(exp));
`endif
    endtask

    task automatic run_t1(input string tag, input logic [6:0] exp_y);
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b0, 1'b1, {3'b000, T1_BITS[6-i]});
            check($sformatf("%s_bit%0d", tag, i + 1), 32'(y_out), 32'({3'b000, exp_y[6-i]}));
        end
    endtask

    initial begin
        logic [CH-1:0] exp_y;
        logic [CH-1:0] bits;

        // Reset state
        reset_dut();
        check("reset_y", 32'(y_out), 32'h0);
        check_cnt("reset_cnt", 8'h00);

        // 1. Overlapping detection
        pattern = 4'b1011;
        overlap = 1'b1;
        run_t1("ovl", T1_OVL);
        check_cnt("ovl_cnt", 8'h02);

        // 2. Non-overlapping detection
        reset_dut();
        overlap = 1'b0;
        run_t1("nov", T1_NOV);
        check_cnt("nov_cnt", 8'h01);

        // 3. Fill guard with an all-zero pattern on every lane
        reset_dut();
        pattern = 4'b0000;
        overlap = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b1, 4'b0000);
            check($sformatf("zero_bit%0d", i + 1), 32'(y_out), (i < 3) ? 32'h0 : 32'hF);
        end
        check_cnt("zero_cnt_sat", 8'hFF);

        // 4a. Gap tolerated
        reset_dut();
        pattern = 4'b1011;
        overlap = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 4'b0001);
        drive(1'b0, 1'b0, 1'b1, 4'b0000);
        drive(1'b0, 1'b0, 1'b1, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 4'b0001);
            check($sformatf("gap_idle%0d", i), 32'(y_out), 32'h0);
        end
        drive(1'b0, 1'b0, 1'b1, 4'b0001);
        check("gap_hit", 32'(y_out), 32'h1);

        // 4b. clr during the gap discards the partial match and its own bit
        reset_dut();
        drive(1'b0, 1'b0, 1'b1, 4'b0001);
        drive(1'b0, 1'b0, 1'b1, 4'b0000);
        drive(1'b0, 1'b0, 1'b1, 4'b0001);
        drive(1'b0, 1'b0, 1'b0, 4'b0000);
        drive(1'b0, 1'b1, 1'b1, 4'b0001);
        check("clr_y", 32'(y_out), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, {3'b000, SEQ[3-i]});
            check($sformatf("clr_new_bit%0d", i + 1), 32'(y_out), (i == 3) ? 32'h1 : 32'h0);
        end

        // 5. Staggered lanes, non-overlapping, counters saturate at 3
        reset_dut();
        overlap = 1'b0;
        for (int t = 0; t < 23; t++) begin
            for (int c = 0; c < CH; c++) begin
                bits[c]  = (t - c >= 0 && t - c < 20) ? SEQ[3 - ((t - c) % 4)] : 1'b0;
                exp_y[c] = (t - c >= 3 && t - c < 20 && (t - c) % 4 == 3);
            end
            drive(1'b0, 1'b0, 1'b1, bits);
            check($sformatf("stag_t%0d", t), 32'(y_out), 32'(exp_y));
        end
        check_cnt("stag_cnt_sat", 8'hFF);

        // 5b. rst mid-stream wins over a valid bit that would complete a match
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, {CH{SEQ[3-i]}});
        drive(1'b1, 1'b0, 1'b1, 4'hF);
        check("rst_mid_y", 32'(y_out), 32'h0);
        check_cnt("rst_mid_cnt", 8'h00);
        for (int i = 1; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, {CH{SEQ[3-i]}});
            check($sformatf("rst_after_bit%0d", i), 32'(y_out), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
